lcd_serial_rx: RTL and testbench
================================

// Module: lcd_serial_rx
// PURPOSE
//  Panel-side receiver for the 4-wire serial LCD link (cs1/rs/sclk/sid). Deserialises bytes, decodes
//  the panel command set (page/column address, display on/off, start line, soft reset) and writes
//  data bytes into a page-organised display RAM. Used as a synthesizable loop-back sink/panel model
//  behind the LCD controller, and as the scoreboard source for LCD verification.
// PARAMETERS
//  SYNC_STAGES  2    synchroniser depth on cs1/rs/sclk/sid (>=2)
//  NUM_PAGES    16   display RAM pages (8 rows each); page index width 4
//  NUM_COLS     128  columns per page; column index width 7
// PORTS
//  clk          in   1  system clock
//  rstn         in   1  asynchronous, active-low reset
//  I_reset      in   1  panel reset pin, active-low, sampled synchronously (after sync)
//  I_cs1        in   1  chip select, active-low
//  I_rs         in   1  1 = data byte, 0 = command byte
//  I_sclk       in   1  serial clock; sid sampled on its rising edge
//  I_sid        in   1  serial data, MSB first
//  I_rd_page    in   4  display RAM read page
//  I_rd_col     in   7  display RAM read column
//  O_rd_data    out  8  dram[I_rd_page][I_rd_col], combinational read
//  O_cmd_valid  out  1  one-cycle pulse: command byte committed
//  O_cmd        out  8  last committed command byte
//  O_data_valid out  1  one-cycle pulse: data byte committed
//  O_page       out  4  current page address
//  O_col        out  7  current column address
//  O_start_line out  6  display start line
//  O_disp_on    out  1  display on flag
//  O_frame_err  out  1  one-cycle pulse: cs1 deasserted mid-byte
// BEHAVIOUR
//  - Reset (rstn low): all outputs and state 0, FSM IDLE, shift reg and bit count 0; RAM not cleared.
//  - Inputs pass SYNC_STAGES flops; sclk edge detect on synced copy. Each sclk high and low phase
//    must be >= SYNC_STAGES+1 clk; faster links are out of spec.
//  - FSM: IDLE (cs1 high) -> SHIFT on synced cs1 low. SHIFT: per synced sclk rise, shreg<={shreg,sid},
//    bit_cnt++. 8th rise -> COMMIT with rs sampled at that edge. COMMIT (1 clk): act on byte, bit_cnt=0,
//    -> SHIFT if cs1 low else IDLE. Pulses assert in the COMMIT cycle (2 clk after synced 8th edge).
//  - cs1 rising in SHIFT with bit_cnt!=0: partial byte discarded, O_frame_err pulses, -> IDLE.
//    With bit_cnt==0: -> IDLE silently. sclk edges while cs1 high are ignored.
//  - Data byte (rs=1): dram[O_page][O_col] <= byte; bit7 = row page*8+0 ... bit0 = row page*8+7;
//    O_col <= O_col+1, wrapping NUM_COLS-1 -> 0; page never auto-increments. O_data_valid pulses.
//  - Command byte (rs=0): O_cmd <= byte, O_cmd_valid pulses, then decode:
//    0xB0-0xBF page<=b[3:0]; 0x10-0x1F col[6:4]<=b[2:0]; 0x00-0x0F col[3:0]<=b[3:0];
//    0x40-0x7F start_line<=b[5:0]; 0xAE disp_on<=0; 0xAF disp_on<=1; 0xE2 page,col,start_line<=0.
//    All other bytes: O_cmd_valid only, no state change (multi-byte cmds e.g. 0x81 arg not tracked).
//  - Synced I_reset low: acts like rstn except O_rd_data path and RAM; in-flight byte dropped, no
//    frame_err; held in IDLE until I_reset high. rstn has priority over everything.
//  - RAM write and read to same address in same cycle: O_rd_data shows old byte, new byte next cycle.
// CONFIGURATION
//  LCD_RX_DRAM_EN defined: NUM_PAGES x NUM_COLS x 8 display RAM instantiated, written as above.
//  Undefined: no RAM; O_rd_data tied 8'h00; data bytes still advance O_col and pulse O_data_valid.
// TESTING
//  1 rstn pulse then idle -> all outputs 0, FSM IDLE, O_disp_on=0.
//  2 cmds 0xB3,0x12,0x05 then data 0xA5 -> O_page=3, O_col 0x25->0x26, rd(3,0x25)=0xA5 (DRAM_EN).
//  3 cmd 0x17,0x0F (col 127), data 0x11,0x22 -> rd(p,127)=0x11, rd(p,0)=0x22, O_col=1, page unchanged.
//  4 cs1 high after 5 bits -> O_frame_err one pulse; next full byte 0xAF -> O_disp_on=1, no error.
//  5 cmds 0x7F,0xE2 -> start_line 63 then 0; page/col 0; I_reset low mid-byte -> byte dropped, regs 0.
//  6 without LCD_RX_DRAM_EN: data bytes pulse O_data_valid, O_col advances, O_rd_data stays 0x00.

Source files
------------

// File: rtl/lcd_serial_rx.sv
// lcd_serial_rx: panel-side receiver for the cs1/rs/sclk/sid serial LCD link.
// Deserialises bytes MSB first, decodes the panel command set and tracks
// page/column/start-line/display state. Data bytes advance the column and,
// when LCD_RX_DRAM_EN is defined, are stored in a page-organised display RAM.
// Without LCD_RX_DRAM_EN there is no RAM and O_rd_data reads as 8'h00.
module lcd_serial_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_PAGES   = 16,
   parameter int NUM_COLS    = 128
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       I_reset,
   input  logic       I_cs1,
   input  logic       I_rs,
   input  logic       I_sclk,
   input  logic       I_sid,
   input  logic [3:0] I_rd_page,
   input  logic [6:0] I_rd_col,
   output logic [7:0] O_rd_data,
   output logic       O_cmd_valid,
   output logic [7:0] O_cmd,
   output logic       O_data_valid,
   output logic [3:0] O_page,
   output logic [6:0] O_col,
   output logic [5:0] O_start_line,
   output logic       O_disp_on,
   output logic       O_frame_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

   state_t     r_state;
   state_t     w_next_state;

   logic [4:0] r_sync [SYNC_STAGES];
   logic       w_reset_n;
   logic       w_cs1;
   logic       w_rs;
   logic       w_sclk;
   logic       w_sid;
   logic       r_sclk_d;
   logic       w_sclk_rise;

   logic [7:0] r_shreg;
   logic [2:0] r_bit_cnt;
   logic       r_rs_lat;
   logic [7:0] r_cmd;
   logic [3:0] r_page;
   logic [6:0] r_col;
   logic [5:0] r_start_line;
   logic       r_disp_on;

   logic       w_commit_cmd;
   logic       w_commit_data;
   logic       w_frame_err;
   logic [6:0] w_col_inc;

   // Bring the asynchronous pins into the clk domain; idle levels keep cs1 and panel reset inactive
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 5'b11000;
      end else begin
         r_sync[0] <= {I_reset, I_cs1, I_rs, I_sclk, I_sid};
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   assign {w_reset_n, w_cs1, w_rs, w_sclk, w_sid} = r_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk & ~r_sclk_d;
   assign w_col_inc   = (r_col == 7'(NUM_COLS - 1)) ? 7'd0 : r_col + 7'd1;

   // Delayed copy of the synced serial clock for rising-edge detection
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_sclk_d <= 1'b0;
      else       r_sclk_d <= w_sclk;
   end

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state and pulse decode; panel reset forces IDLE and suppresses every pulse
   always_comb begin
      w_next_state  = r_state;
      w_commit_cmd  = 1'b0;
      w_commit_data = 1'b0;
      w_frame_err   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_cs1) w_next_state = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (w_cs1) begin
               w_next_state = ST_IDLE;
               w_frame_err  = (r_bit_cnt != 3'd0);
            end else if (w_sclk_rise && r_bit_cnt == 3'd7) begin
               w_next_state = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            w_commit_cmd  = ~r_rs_lat;
            w_commit_data = r_rs_lat;
            w_next_state  = w_cs1 ? ST_IDLE : ST_SHIFT;
         end
         default: w_next_state = ST_IDLE;
      endcase
      if (!w_reset_n) begin
         w_next_state  = ST_IDLE;
         w_commit_cmd  = 1'b0;
         w_commit_data = 1'b0;
         w_frame_err   = 1'b0;
      end
   end

   // Shift register, bit counter and the panel state acted on by committed bytes
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_shreg      <= 8'h00;
         r_bit_cnt    <= 3'd0;
         r_rs_lat     <= 1'b0;
         r_cmd        <= 8'h00;
         r_page       <= 4'd0;
         r_col        <= 7'd0;
         r_start_line <= 6'd0;
         r_disp_on    <= 1'b0;
      end else if (!w_reset_n) begin
         r_shreg      <= 8'h00;
         r_bit_cnt    <= 3'd0;
         r_rs_lat     <= 1'b0;
         r_cmd        <= 8'h00;
         r_page       <= 4'd0;
         r_col        <= 7'd0;
         r_start_line <= 6'd0;
         r_disp_on    <= 1'b0;
      end else begin
         case (r_state)
            ST_SHIFT: begin
               if (w_cs1) begin
                  r_bit_cnt <= 3'd0;
                  r_shreg   <= 8'h00;
               end else if (w_sclk_rise) begin
                  r_shreg   <= {r_shreg[6:0], w_sid};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) r_rs_lat <= w_rs;
               end
            end
            ST_COMMIT: begin
               r_bit_cnt <= 3'd0;
               if (r_rs_lat) begin
                  r_col <= w_col_inc;
               end else begin
                  r_cmd <= r_shreg;
                  if (r_shreg[7:4] == 4'hB) begin
                     r_page <= r_shreg[3:0];
                  end else if (r_shreg[7:4] == 4'h1) begin
                     r_col[6:4] <= r_shreg[2:0];
                  end else if (r_shreg[7:4] == 4'h0) begin
                     r_col[3:0] <= r_shreg[3:0];
                  end else if (r_shreg[7:6] == 2'b01) begin
                     r_start_line <= r_shreg[5:0];
                  end else if (r_shreg == 8'hAE) begin
                     r_disp_on <= 1'b0;
                  end else if (r_shreg == 8'hAF) begin
                     r_disp_on <= 1'b1;
                  end else if (r_shreg == 8'hE2) begin
                     r_page       <= 4'd0;
                     r_col        <= 7'd0;
                     r_start_line <= 6'd0;
                  end
               end
            end
            default: r_bit_cnt <= 3'd0;
         endcase
      end
   end

`ifdef LCD_RX_DRAM_EN
   logic [7:0] r_dram [NUM_PAGES * NUM_COLS];

   // Display RAM write at the current page/column; contents survive both resets
   always_ff @(posedge clk) begin
      if (w_commit_data) r_dram[{r_page, r_col}] <= r_shreg;
   end

   assign O_rd_data = r_dram[{I_rd_page, I_rd_col}];
`else
   logic w_unused_rd;
   assign w_unused_rd = ^{I_rd_page, I_rd_col};
   assign O_rd_data   = 8'h00;
`endif

   assign O_cmd_valid  = w_commit_cmd;
   assign O_data_valid = w_commit_data;
   assign O_frame_err  = w_frame_err;
   assign O_cmd        = r_cmd;
   assign O_page       = r_page;
   assign O_col        = r_col;
   assign O_start_line = r_start_line;
   assign O_disp_on    = r_disp_on;

endmodule

// File: tb/tb_lcd_serial_rx.sv
// tb_lcd_serial_rx: directed test of the serial LCD receiver against a
// transaction-level panel model. Honours LCD_RX_DRAM_EN the same way the design does.
module tb_lcd_serial_rx;

   logic       clk;
   logic       rstn;
   logic       I_reset;
   logic       I_cs1;
   logic       I_rs;
   logic       I_sclk;
   logic       I_sid;
   logic [3:0] I_rd_page;
   logic [6:0] I_rd_col;
   logic [7:0] O_rd_data;
   logic       O_cmd_valid;
   logic [7:0] O_cmd;
   logic       O_data_valid;
   logic [3:0] O_page;
   logic [6:0] O_col;
   logic [5:0] O_start_line;
   logic       O_disp_on;
   logic       O_frame_err;

   int nVec;
   int nErr;

   // Panel model state
   int         mPage;
   int         mCol;
   int         mStart;
   int         mDisp;
   int         mCmd;
   logic [7:0] mRam [2048];
   bit         mWr [2048];
   logic [8:0] expQ [$];
   logic [8:0] popped;
   int         obsFe;
   int         expFe;
   bit         chkEn;
   int         rdIdx;

   lcd_serial_rx dut (
      .clk          (clk),
      .rstn         (rstn),
      .I_reset      (I_reset),
      .I_cs1        (I_cs1),
      .I_rs         (I_rs),
      .I_sclk       (I_sclk),
      .I_sid        (I_sid),
      .I_rd_page    (I_rd_page),
      .I_rd_col     (I_rd_col),
      .O_rd_data    (O_rd_data),
      .O_cmd_valid  (O_cmd_valid),
      .O_cmd        (O_cmd),
      .O_data_valid (O_data_valid),
      .O_page       (O_page),
      .O_col        (O_col),
      .O_start_line (O_start_line),
      .O_disp_on    (O_disp_on),
      .O_frame_err  (O_frame_err)
   );

   // 100 MHz system clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nErr++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Send one byte (or the first nbits of it) over the serial link; last releases cs1
   task automatic applyStimulus(input logic rs, input logic [7:0] b, input int nbits, input bit last);
      if (nbits == 8) expQ.push_back({rs, b});
      else            expFe++;
      I_cs1 = 1'b0;
      I_rs  = rs;
      tick(4);
      for (int i = 0; i < nbits; i++) begin
         I_sid = b[7-i];
         tick(4);
         I_sclk = 1'b1;
         tick(4);
         I_sclk = 1'b0;
      end
      tick(6);
      if (last) begin
         I_cs1 = 1'b1;
         tick(8);
         checkOutput("pending_bytes", expQ.size(), 0);
      end
   endtask

   task automatic readAt(input int page, input int col);
      I_rd_page = 4'(page);
      I_rd_col  = 7'(col);
      #1;
   endtask

   // Per-cycle comparison of the DUT against the panel model; model updates after compare
   always @(negedge clk) begin
      if (rstn) begin
         if (chkEn) begin
            checkOutput("page", 32'(O_page), mPage);
            checkOutput("col", 32'(O_col), mCol);
            checkOutput("start_line", 32'(O_start_line), mStart);
            checkOutput("disp_on", 32'(O_disp_on), mDisp);
            checkOutput("cmd", 32'(O_cmd), mCmd);
            rdIdx = int'(I_rd_page) * 128 + int'(I_rd_col);
`ifdef LCD_RX_DRAM_EN
            if (mWr[rdIdx]) checkOutput("rd_data", 32'(O_rd_data), 32'(mRam[rdIdx]));
`else
            checkOutput("rd_data", 32'(O_rd_data), 0);
`endif
         end
         if (O_frame_err) obsFe++;
         if (O_cmd_valid && O_data_valid) begin
            checkOutput("both_valid", 1, 0);
         end else if (O_cmd_valid || O_data_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_pulse", 1, 0);
            end else begin
               popped = expQ.pop_front();
               checkOutput("pulse_kind", 32'(O_data_valid), 32'(popped[8]));
               if (popped[8]) begin
                  mRam[mPage * 128 + mCol] = popped[7:0];
                  mWr[mPage * 128 + mCol]  = 1'b1;
                  mCol = (mCol + 1) % 128;
               end else begin
                  mCmd = popped[7:0];
                  if (mCmd >= 'hB0 && mCmd <= 'hBF)      mPage  = mCmd - 'hB0;
                  else if (mCmd >= 'h10 && mCmd <= 'h1F) mCol   = (mCmd % 8) * 16 + (mCol % 16);
                  else if (mCmd <= 'h0F)                 mCol   = (mCol / 16) * 16 + mCmd;
                  else if (mCmd >= 'h40 && mCmd <= 'h7F) mStart = mCmd - 'h40;
                  else if (mCmd == 'hAE)                 mDisp  = 0;
                  else if (mCmd == 'hAF)                 mDisp  = 1;
                  else if (mCmd == 'hE2) begin
                     mPage  = 0;
                     mCol   = 0;
                     mStart = 0;
                  end
               end
            end
         end
      end
   end

   initial begin
      nVec = 0; nErr = 0;
      mPage = 0; mCol = 0; mStart = 0; mDisp = 0; mCmd = 0;
      obsFe = 0; expFe = 0; chkEn = 1'b0; rdIdx = 0;
      for (int i = 0; i < 2048; i++) mWr[i] = 1'b0;
      rstn = 1'b0; I_reset = 1'b1; I_cs1 = 1'b1; I_rs = 1'b0;
      I_sclk = 1'b0; I_sid = 1'b0; I_rd_page = 4'd0; I_rd_col = 7'd0;
      tick(5);
      rstn = 1'b1;
      tick(5);

      // Reset state
      checkOutput("rst_page", 32'(O_page), 0);
      checkOutput("rst_col", 32'(O_col), 0);
      checkOutput("rst_disp_on", 32'(O_disp_on), 0);
      checkOutput("rst_cmd", 32'(O_cmd), 0);
      checkOutput("rst_start", 32'(O_start_line), 0);
      checkOutput("rst_pulses", 32'({O_cmd_valid, O_data_valid, O_frame_err}), 0);
      chkEn = 1'b1;

      // Page/column addressing and one data byte
      readAt(3, 'h25);
      applyStimulus(1'b0, 8'hB3, 8, 1'b1);
      applyStimulus(1'b0, 8'h12, 8, 1'b1);
      applyStimulus(1'b0, 8'h05, 8, 1'b1);
      checkOutput("t2_col_before", 32'(O_col), 'h25);
      applyStimulus(1'b1, 8'hA5, 8, 1'b1);
      checkOutput("t2_page", 32'(O_page), 3);
      checkOutput("t2_col_after", 32'(O_col), 'h26);
      checkOutput("t2_cmd", 32'(O_cmd), 'h05);
`ifdef LCD_RX_DRAM_EN
      checkOutput("t2_rd", 32'(O_rd_data), 'hA5);
`else
      checkOutput("t2_rd", 32'(O_rd_data), 0);
`endif

      // Column wrap at 127, two data bytes in one cs1 frame
      applyStimulus(1'b0, 8'h17, 8, 1'b1);
      applyStimulus(1'b0, 8'h0F, 8, 1'b1);
      checkOutput("t3_col127", 32'(O_col), 127);
      applyStimulus(1'b1, 8'h11, 8, 1'b0);
      applyStimulus(1'b1, 8'h22, 8, 1'b1);
      checkOutput("t3_col", 32'(O_col), 1);
      checkOutput("t3_page", 32'(O_page), 3);
      readAt(3, 127);
`ifdef LCD_RX_DRAM_EN
      checkOutput("t3_rd127", 32'(O_rd_data), 'h11);
      readAt(3, 0);
      checkOutput("t3_rd0", 32'(O_rd_data), 'h22);
`else
      checkOutput("t3_rd127", 32'(O_rd_data), 0);
`endif

      // Partial byte then a clean display-on command
      applyStimulus(1'b0, 8'hFF, 5, 1'b1);
      checkOutput("t4_fe_cnt", obsFe, 1);
      applyStimulus(1'b0, 8'hAF, 8, 1'b1);
      checkOutput("t4_disp_on", 32'(O_disp_on), 1);
      checkOutput("t4_fe_cnt2", obsFe, 1);

      // Start line, soft reset, unknown command, then panel reset mid-byte
      applyStimulus(1'b0, 8'h7F, 8, 1'b1);
      checkOutput("t5_start63", 32'(O_start_line), 63);
      applyStimulus(1'b0, 8'hE2, 8, 1'b1);
      checkOutput("t5_start0", 32'(O_start_line), 0);
      checkOutput("t5_page0", 32'(O_page), 0);
      checkOutput("t5_col0", 32'(O_col), 0);
      checkOutput("t5_disp_kept", 32'(O_disp_on), 1);
      applyStimulus(1'b0, 8'h81, 8, 1'b1);
      checkOutput("t5_cmd81", 32'(O_cmd), 'h81);
      applyStimulus(1'b0, 8'hB5, 8, 1'b1);
      applyStimulus(1'b0, 8'h13, 8, 1'b1);
      checkOutput("t5_page5", 32'(O_page), 5);
      chkEn = 1'b0;
      I_cs1 = 1'b0;
      I_rs  = 1'b1;
      tick(4);
      for (int i = 0; i < 3; i++) begin
         I_sid = 1'b1;
         tick(4);
         I_sclk = 1'b1;
         tick(4);
         I_sclk = 1'b0;
      end
      I_reset = 1'b0;
      tick(10);
      I_cs1 = 1'b1;
      tick(6);
      mPage = 0; mCol = 0; mStart = 0; mDisp = 0; mCmd = 0;
      checkOutput("t5_rst_page", 32'(O_page), 0);
      checkOutput("t5_rst_col", 32'(O_col), 0);
      checkOutput("t5_rst_disp", 32'(O_disp_on), 0);
      I_reset = 1'b1;
      tick(6);
      chkEn = 1'b1;
      checkOutput("t5_fe_none", obsFe, expFe);

      // Data after panel reset lands at page 0 column 0
      readAt(0, 0);
      applyStimulus(1'b1, 8'h3C, 8, 1'b1);
      checkOutput("t6_col", 32'(O_col), 1);
      checkOutput("t6_cmd", 32'(O_cmd), 0);
      checkOutput("end_fe", obsFe, expFe);
      checkOutput("end_queue", expQ.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
